// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin sharing of a tiny cache between two requesters,
// with read-miss fill from backing memory and a bounded memory wait.
module cache_req_arbiter #(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic              cache_req_valid,
  output logic              cache_req_rw,
  output logic [ADDR_W-1:0] cache_req_addr,
  output logic [DATA_W-1:0] cache_req_wdata,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] CACHE_REQ  = 3'd1;
  localparam logic [2:0] CACHE_WAIT = 3'd2;
  localparam logic [2:0] MEM_REQ    = 3'd3;
  localparam logic [2:0] MEM_WAIT   = 3'd4;
  localparam logic [2:0] FILL       = 3'd5;
  localparam logic [2:0] RESP       = 3'd6;

  logic [2:0]        r_state;
  logic              r_last;
  logic              r_id;
  logic              r_rw;
  logic              r_hit;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_idle;
  logic              w_any;
  logic              w_gnt;
  logic              w_fill;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_idle    = r_state == IDLE;
  assign w_any     = req0_valid | req1_valid;
  // on a tie the requester not served last wins
  assign w_gnt     = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_fill    = r_state == FILL;
  assign w_timeout = r_cnt >= CNT_W'(MEM_TIMEOUT - 1);
  assign w_cnt_inc = (r_cnt == CNT_W'(MEM_TIMEOUT)) ? r_cnt : r_cnt + CNT_W'(1);

  assign req0_ready = ~rst & w_idle & w_any & ~w_gnt;
  assign req1_ready = ~rst & w_idle & w_any & w_gnt;
  assign busy       = ~w_idle;

  assign rsp_valid = r_state == RESP;
  assign rsp_id    = rsp_valid & r_id;
  assign rsp_rdata = rsp_valid ? r_data : '0;
  assign rsp_hit   = rsp_valid & r_hit;
  assign rsp_err   = rsp_valid & r_err;

  assign cache_req_valid = (r_state == CACHE_REQ) | w_fill;
  assign cache_req_rw    = w_fill | (cache_req_valid & r_rw);
  assign cache_req_addr  = cache_req_valid ? r_addr : '0;
  assign cache_req_wdata = w_fill ? r_data : (r_state == CACHE_REQ ? r_wdata : '0);

  assign mem_req_valid = r_state == MEM_REQ;
  assign mem_req_addr  = mem_req_valid ? r_addr : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_rw    <= 1'b0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else
      case (r_state)
        IDLE:
          if (w_any) begin
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_rw    <= w_gnt ? req1_rw : req0_rw;
            r_addr  <= w_gnt ? req1_addr : req0_addr;
            r_wdata <= w_gnt ? req1_wdata : req0_wdata;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_state <= CACHE_REQ;
          end
        CACHE_REQ: r_state <= CACHE_WAIT;
        CACHE_WAIT: begin
          r_hit   <= cache_hit;
          r_data  <= (!r_rw && cache_hit) ? cache_rdata : '0;
          r_cnt   <= '0;
          r_state <= (r_rw || cache_hit) ? RESP : MEM_REQ;
        end
        MEM_REQ: begin
          r_cnt <= w_cnt_inc;
          if (mem_req_ready) r_state <= MEM_WAIT;
          else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end
        end
        MEM_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (mem_rsp_valid) begin
            r_data  <= mem_rsp_data;
            r_state <= FILL;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end
        end
        FILL:    r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed vectors for cache_req_arbiter against a small cache and memory model.
module tb_cache_req_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_rw = 1'b0;
  logic [1:0] req0_addr = '0, req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_rw = 1'b0;
  logic [1:0] req1_addr = '0, req1_wdata = '0;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_hit, rsp_err;
  logic [1:0] rsp_rdata;
  logic       cache_req_valid, cache_req_rw;
  logic [1:0] cache_req_addr, cache_req_wdata;
  logic       cache_hit;
  logic [1:0] cache_rdata;
  logic       mem_req_valid;
  logic [1:0] mem_req_addr;
  logic       mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [1:0] mem_rsp_data = '0;
  logic       busy;

  cache_req_arbiter #(.ADDR_W(2), .DATA_W(2), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .cache_req_valid(cache_req_valid), .cache_req_rw(cache_req_rw),
    .cache_req_addr(cache_req_addr), .cache_req_wdata(cache_req_wdata),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // 4-entry cache with registered hit/data one cycle after the strobe
  logic [3:0] cv;
  logic [1:0] cd [4];
  always @(posedge clk or posedge rst)
    if (rst) begin
      cv          <= '0;
      cache_hit   <= 1'b0;
      cache_rdata <= '0;
    end else if (cache_req_valid) begin
      cache_hit   <= cv[cache_req_addr];
      cache_rdata <= (!cache_req_rw && cv[cache_req_addr]) ? cd[cache_req_addr] : 2'd0;
      if (cache_req_rw) begin
        cv[cache_req_addr] <= 1'b1;
        cd[cache_req_addr] <= cache_req_wdata;
      end
    end

  // backing memory: ready after ready_dly MEM_REQ cycles, data the cycle after acceptance
  logic [1:0] mem_arr [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
  int         ready_dly = 0;
  bit         stray_en = 0, rsp_hold = 0, pend = 0;
  int         wcnt = 0;
  logic [1:0] exp_maddr = '0;
  int         n_strobe = 0, n_mreq = 0, n_addr_bad = 0, n_rsp = 0;

  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    if (rsp_valid) n_rsp++;
    if (rst) begin
      mem_req_ready = 1'b0;
      pend = 0;
      wcnt = 0;
    end else begin
      if (cache_req_valid) n_strobe++;
      if (pend && !rsp_hold) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_arr[exp_maddr];
      end
      pend = 0;
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        n_mreq++;
        if (mem_req_addr !== exp_maddr) n_addr_bad++;
        if (stray_en && wcnt == 1) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = ~mem_arr[exp_maddr];
        end
        if (wcnt == ready_dly) begin
          mem_req_ready = 1'b1;
          pend = 1;
        end
        wcnt++;
      end else wcnt = 0;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       id;
    logic       rw;
    logic [1:0] addr;
    logic [1:0] wdata;
    int         rdly;
    bit         stray;
    logic       hit;
    logic [1:0] rdata;
    logic       err;
    int         lat;
    int         strobes;
    int         mreq;
  } vec_t;

  vec_t vt [10];

  task automatic run_vec(input int k);
    vec_t v;
    int   lat, s0, m0, b0;
    v = vt[k];
    @(negedge clk);
    ready_dly = v.rdly;
    stray_en  = v.stray;
    exp_maddr = v.addr;
    s0 = n_strobe;
    m0 = n_mreq;
    b0 = n_addr_bad;
    if (v.id) begin
      req1_valid = 1'b1; req1_rw = v.rw; req1_addr = v.addr; req1_wdata = v.wdata;
    end else begin
      req0_valid = 1'b1; req0_rw = v.rw; req0_addr = v.addr; req0_wdata = v.wdata;
    end
    #1;
    chk($sformatf("v%0d_accept", k), int'(v.id ? req1_ready : req0_ready), 1);
    chk($sformatf("v%0d_other_ready", k), int'(v.id ? req0_ready : req1_ready), 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (!rsp_valid && lat < 40);
    chk($sformatf("v%0d_latency", k), lat, v.lat);
    chk($sformatf("v%0d_rsp_id", k), int'(rsp_id), int'(v.id));
    chk($sformatf("v%0d_rsp_hit", k), int'(rsp_hit), int'(v.hit));
    chk($sformatf("v%0d_rsp_rdata", k), int'(rsp_rdata), int'(v.rdata));
    chk($sformatf("v%0d_rsp_err", k), int'(rsp_err), int'(v.err));
    chk($sformatf("v%0d_busy_resp", k), int'(busy), 1);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_rsp_pulse", k), int'(rsp_valid), 0);
    chk($sformatf("v%0d_busy_drop", k), int'(busy), 0);
    chk($sformatf("v%0d_cache_strobes", k), n_strobe - s0, v.strobes);
    chk($sformatf("v%0d_mem_req_cycles", k), n_mreq - m0, v.mreq);
    chk($sformatf("v%0d_mem_addr_stable", k), n_addr_bad - b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, r0, ng;
    bit  prev;
    bit  gseq [4];
    //         id rw a  wd rdly st  hit rd err lat str mreq
    vt[0] = '{1'b0, 1'b1, 2'd2, 2'd3, 0,  1'b0, 1'b0, 2'd0, 1'b0, 3,  1, 0};
    vt[1] = '{1'b0, 1'b0, 2'd2, 2'd0, 0,  1'b0, 1'b1, 2'd3, 1'b0, 3,  1, 0};
    vt[2] = '{1'b1, 1'b0, 2'd1, 2'd0, 0,  1'b0, 1'b0, 2'd2, 1'b0, 6,  2, 1};
    vt[3] = '{1'b1, 1'b0, 2'd1, 2'd0, 0,  1'b0, 1'b1, 2'd2, 1'b0, 3,  1, 0};
    vt[4] = '{1'b0, 1'b0, 2'd0, 2'd0, 99, 1'b0, 1'b0, 2'd0, 1'b1, 18, 1, 15};
    vt[5] = '{1'b1, 1'b0, 2'd0, 2'd0, 4,  1'b1, 1'b0, 2'd1, 1'b0, 10, 2, 5};
    vt[6] = '{1'b0, 1'b1, 2'd1, 2'd1, 0,  1'b0, 1'b1, 2'd0, 1'b0, 3,  1, 0};
    vt[7] = '{1'b1, 1'b0, 2'd1, 2'd0, 0,  1'b0, 1'b1, 2'd1, 1'b0, 3,  1, 0};
    vt[8] = '{1'b0, 1'b0, 2'd3, 2'd0, 0,  1'b0, 1'b0, 2'd3, 1'b0, 6,  2, 1};
    vt[9] = '{1'b1, 1'b1, 2'd3, 2'd0, 0,  1'b0, 1'b1, 2'd0, 1'b0, 3,  1, 0};

    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_req1_ready", int'(req1_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_cache_req_valid", int'(cache_req_valid), 0);
    chk("rst_mem_req_valid", int'(mem_req_valid), 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) run_vec(k);

    // reset while waiting for memory data
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rsp_hold  = 1;
    ready_dly = 0;
    stray_en  = 0;
    exp_maddr = 2'd0;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 2'd0;
    #1;
    chk("mid_accept", int'(req1_ready), 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_mem_req", int'(mem_req_valid), 1);
    @(negedge clk);
    #1;
    chk("mid_wait_busy", int'(busy), 1);
    chk("mid_wait_no_req", int'(mem_req_valid), 0);
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 2'd0; req0_wdata = 2'd1;
    req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 2'd1; req1_wdata = 2'd2;
    r0 = n_rsp;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mem_req", int'(mem_req_valid), 0);
    chk("mid_rst_cache_req", int'(cache_req_valid), 0);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_ready", int'(req0_ready | req1_ready), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rst_no_rsp", n_rsp - r0, 0);
    @(negedge clk);
    rst = 1'b0;
    rsp_hold = 0;

    // both requesters held valid: grants must alternate starting with req0
    ng = 0;
    prev = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        chk("arb_both_ready", int'(req0_ready & req1_ready), 0);
        chk("arb_ready_pulse", int'(prev), 0);
        gseq[ng] = req1_ready;
        ng++;
        prev = 1;
      end else prev = 0;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("arb_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_grant%0d", i), int'(gseq[i]), i % 2);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("arb_final_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Sequences and shares the 4-entry, 2-bit tiny cache between two requesters (req0, req1) using round-robin arbitration.
- Issues one cache access per granted request and waits the cache's 1-cycle registered hit/data latency.
- On a read miss, fetches the word from backing memory, writes it into the cache, then returns it to the requester.
- Sits between requester ports and the cache request interface. The cache enable is tied high at top level.

Parameters:
- ADDR_W, 2, address width (cache has 4 entries)
- DATA_W, 2, data width
- MEM_TIMEOUT, 15, max cycles spent in MEM_REQ+MEM_WAIT before an error response

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  request pending (N=0,1)
- reqN_ready  out  1  one-cycle accept pulse; request fields captured on this edge
- reqN_rw  in  1  1=write, 0=read
- reqN_addr  in  ADDR_W  address
- reqN_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  requester served (0/1)
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_hit  out  1  cache hit flag for the access
- rsp_err  out  1  memory timeout
- cache_req_valid  out  1  cache request strobe
- cache_req_rw  out  1  cache rw
- cache_req_addr  out  ADDR_W  cache address
- cache_req_wdata  out  DATA_W  cache write data
- cache_hit  in  1  registered hit, valid the cycle after the strobe
- cache_rdata  in  DATA_W  registered read data, same timing
- mem_req_valid  out  1  backing fetch request, held until accepted
- mem_req_addr  out  ADDR_W  fetch address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  fetch data valid
- mem_rsp_data  in  DATA_W  fetch data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; timeout counter 0; round-robin pointer set so req0 wins the first tie. Reset mid-transaction aborts it with no response.
- FSM states: IDLE, CACHE_REQ, CACHE_WAIT, MEM_REQ, MEM_WAIT, FILL, RESP.
- IDLE:
  - Only one reqN_valid: grant it.
  - Both valid: grant the requester not granted last.
  - reqN_ready=1 combinationally in IDLE for the granted requester only. On that edge, capture id/rw/addr/wdata, update the pointer, go to CACHE_REQ.
  - No request: stay.
- CACHE_REQ: cache_req_valid=1 for exactly one cycle, with the captured rw/addr/wdata -> CACHE_WAIT.
- CACHE_WAIT: sample cache_hit/cache_rdata.
  - Write (hit or miss; the cache self-allocates on write miss) -> RESP with rsp_hit=cache_hit, rdata=0.
  - Read hit -> RESP with rdata=cache_rdata, hit=1.
  - Read miss -> MEM_REQ; clear timeout counter.
- MEM_REQ: mem_req_valid=1, mem_req_addr=captured addr; stays asserted and stable until mem_req_ready=1 -> MEM_WAIT.
- MEM_WAIT: on mem_rsp_valid, latch mem_rsp_data -> FILL.
- Timeout:
  - Counter increments every cycle in MEM_REQ and MEM_WAIT.
  - When it reaches MEM_TIMEOUT without completion -> RESP with err=1, rdata=0, hit=0, and no fill.
  - Counter width is clog2(MEM_TIMEOUT+1) and it saturates, never wraps.
- FILL: cache_req_valid=1, rw=1, addr=captured, wdata=fetched data, for one cycle -> RESP with rdata=fetched, hit=0.
- RESP: rsp_valid=1 for one cycle with rsp_id; rsp_* fields are 0 whenever rsp_valid=0 -> IDLE.
- Latency from accept edge T:
  - Hit or write: rsp_valid at T+3.
  - Miss with zero-wait memory (ready in MEM_REQ cycle, rsp the next cycle): rsp_valid at T+6.
  - Next accept no earlier than T+4.
- mem_rsp_valid outside MEM_WAIT is ignored.
- Exactly one transaction is in flight at a time; no reqN_ready is issued while busy=1.
- Requests deasserting before grant are simply not served; there is no retained state per requester.

Test Plan:
- Write then read (serialized): req0 write addr=2 data=3 -> rsp id=0 (hit=0, first write) at T+3. Then req0 read addr=2 -> rsp hit=1, rdata=3 at T+3.
- Read miss with fill: req1 read addr=1 on cold cache; memory ready immediately, returns 2 one cycle later -> mem_req_addr=1, FILL writes 2, rsp id=1 hit=0 rdata=2. A repeat read returns hit=1 rdata=2.
- Arbitration: req0 and req1 held valid continuously -> grants alternate 0,1,0,1; first grant is req0 after reset; each ready pulse lasts one cycle.
- Timeout: read miss with mem_req_ready stuck 0 -> after 15 cycles in MEM_REQ, rsp err=1 rdata=0 hit=0; no FILL strobe; busy drops the cycle after.
- Stall handling: mem_req_ready delayed 4 cycles -> mem_req_valid/addr stable throughout. A stray mem_rsp_valid during MEM_REQ is ignored; the response after acceptance is used.
- Reset mid-op: assert rst during MEM_WAIT -> all outputs 0 immediately, no rsp_valid. After release, req0 and req1 both valid -> req0 granted first.
